// File: rtl/tick_prescaler_if.sv
// Control/status bundle between a tick_prescaler and its controller.
interface tick_prescaler_if #(
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 32
);
  logic                   start;
  logic                   stop;
  logic                   pause;
  logic [DIV_WIDTH-1:0]   div;
  logic [BURST_WIDTH-1:0] burst;
  logic                   tick;
  logic                   done;
  logic                   busy;
  logic [BURST_WIDTH-1:0] ticks_left;

  modport master (
    output start, stop, pause, div, burst,
    input  tick, done, busy, ticks_left
  );

  modport slave (
    input  start, stop, pause, div, burst,
    output tick, done, busy, ticks_left
  );
endinterface

// File: rtl/tick_prescaler.sv
// Programmable tick (enable pulse) generator: divides clk by div+1, continuous or burst mode.
// Optional TICK_PRESCALER_AUTORELOAD_EN: a finished burst reloads and keeps running.
module tick_prescaler #(
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  tick_prescaler_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

  logic [1:0]             state;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   pre;
  logic [BURST_WIDTH-1:0] burst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      div_q          <= '0;
      pre            <= '0;
      burst_q        <= '0;
      bus.tick       <= 1'b0;
      bus.done       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.ticks_left <= '0;
    end else begin
      bus.tick <= 1'b0;
      bus.done <= 1'b0;
      if (state != IDLE && bus.stop) begin
        state          <= IDLE;
        bus.ticks_left <= '0;
        bus.busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.stop) begin
              state          <= RUN;
              div_q          <= bus.div;
              pre            <= bus.div;
              burst_q        <= bus.burst;
              bus.ticks_left <= bus.burst;
              bus.busy       <= 1'b1;
            end else begin
              // busy lingers one cycle after a completed burst's done pulse
              bus.busy <= 1'b0;
            end
          end
          RUN, PAUSE: begin
            if (bus.pause) begin
              state <= PAUSE;
            end else begin
              // the resume edge counts too, so each pause cycle costs exactly one cycle
              state <= RUN;
              if (pre == '0) begin
                pre      <= div_q;
                bus.tick <= 1'b1;
                if (burst_q != '0) begin
                  if (bus.ticks_left == BURST_ONE) begin
                    bus.done <= 1'b1;
`ifdef TICK_PRESCALER_AUTORELOAD_EN
                    bus.ticks_left <= burst_q;
`else
                    bus.ticks_left <= '0;
                    state          <= IDLE;
`endif
                  end else begin
                    bus.ticks_left <= bus.ticks_left - BURST_ONE;
                  end
                end
              end else begin
                pre <= pre - DIV_WIDTH'(1);
              end
            end
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
